mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  LC-3b pipeline MEM stage. Sits between the EX/MEM register and the MEM/WB register feeding write-back.
//  Runs data-memory handshakes for LDR/LDB/STR/STB and the two-access indirects LDI/STI.
//  Stalls upstream while an access is outstanding. Registers ALU/PC/MAR/MDR results for WB.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max wait for dmem_resp per access (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk            in   1   clock
//  reset_n        in   1   synchronous reset, active low
//  in_valid       in   1   EX/MEM holds a valid instruction; held stable while stall_o=1
//  in_read        in   1   instruction loads memory
//  in_write       in   1   instruction stores memory
//  in_byte        in   1   byte access (LDB/STB)
//  in_indirect    in   1   LDI/STI: first access reads the pointer
//  in_addr        in   16  effective address from EX
//  in_src         in   16  store data (SR)
//  in_alu         in   16  ALU result, passed through
//  in_pc          in   16  PC, passed through
//  stall_o        out  1   hold EX/MEM and earlier stages
//  dmem_address   out  16  word-aligned address {a[15:1],0}
//  dmem_read      out  1   read strobe, held until dmem_resp
//  dmem_write     out  1   write strobe, held until dmem_resp
//  dmem_byte_en   out  2   byte enables
//  dmem_wdata     out  16  write data
//  dmem_rdata     in   16  read data, valid with dmem_resp
//  dmem_resp      in   1   access complete, 1-cycle pulse
//  wb_valid       out  1   MEM/WB entry valid
//  wb_mar         out  16  final byte address (bit0 selects byte lane in WB)
//  wb_mdr         out  16  loaded word
//  wb_alu, wb_pc  out  16  registered pass-through
//  mem_err        out  1   sticky timeout flag (MEM_TIMEOUT_EN only, else tied 0)
// BEHAVIOUR
//  - Reset: state=IDLE. All wb_* = 0, dmem_read/write = 0, stall_o = 0, mem_err = 0.
//  - FSM IDLE -> ACC1 -> [ACC2] -> DONE -> IDLE.
//  - IDLE
//    - in_valid & (in_read|in_write) -> ACC1, stall_o=1. Latch addr; mar <= in_addr.
//    - in_valid & non-memory -> no stall. MEM/WB loads this cycle.
//  - ACC1
//    - dmem_read = in_read|in_indirect; dmem_write = in_write & ~in_indirect.
//    - Strobes and address stay constant until dmem_resp.
//    - On resp, non-indirect -> DONE; mdr <= dmem_rdata on reads.
//    - On resp, indirect -> ACC2; mar <= dmem_rdata (pointer).
//  - ACC2: access at pointer mar (read for LDI, write for STI). On resp -> DONE, mdr <= rdata on reads.
//  - DONE: stall_o=0. MEM/WB loads. -> IDLE. Next instruction is accepted in the following cycle.
//  - stall_o = in_valid & (state!=DONE) & (memory op or state!=IDLE). It is combinational.
//  - MEM/WB load: wb_valid<=1; wb_mar<=mar; wb_mdr<=mdr; wb_alu<=in_alu; wb_pc<=in_pc.
//  - MEM/WB otherwise: wb_valid<=0, and the other wb_* regs hold their values.
//  - Word access: byte_en=2'b11, wdata=in_src. Address bit0 is ignored on the bus but kept in wb_mar.
//  - Byte store: wdata={in_src[7:0],in_src[7:0]}; byte_en = mar[0] ? 2'b10 : 2'b01.
//  - Byte load: byte_en=2'b11. Lane select and zero-extension are done in WB from wb_mar[0].
//  - Indirect pointer access is always a word access.
//  - Latency with resp one cycle after the strobe:
//    - plain load/store: 3 cycles, stall_o high 2 cycles;
//    - LDI/STI: 4 cycles, stall_o high 3 cycles.
//  - dmem_resp outside ACC1/ACC2 is ignored.
//  - Reset mid-access: IDLE next cycle, strobes drop, a late resp is ignored, wb_valid=0.
// CONFIGURATION
//  - MEM_TIMEOUT_EN defined:
//    - An 8+ bit counter clears on each ACC entry and counts cycles without resp.
//    - On reaching TIMEOUT_CYCLES it forces DONE with mdr=16'h0000 and sets mem_err (sticky until reset).
//  - MEM_TIMEOUT_EN undefined: no counter; waits forever; mem_err=0.
// TESTING
//  - Non-memory ADD, in_alu=16'h1234 -> stall_o stays 0; next cycle wb_valid=1, wb_alu=16'h1234.
//  - LDR addr=16'h3001, rdata=16'hBEEF, resp 1 cycle after strobe -> dmem_address=16'h3000,
//    byte_en=11, stall_o 2 cycles, wb_mdr=16'hBEEF, wb_mar=16'h3001.
//  - STB addr=16'h4003, src=16'h00A5 -> dmem_write, wdata=16'hA5A5, byte_en=10.
//  - LDI addr=16'h5000: first rdata=16'h6002, second=16'h7777.
//    -> second access at 16'h6002; wb_mdr=16'h7777, wb_mar=16'h6002.
//  - Resp delayed 5 cycles -> strobes and address stable throughout; stall_o high for 6 cycles.
//  - reset_n low during ACC2 of STI -> next cycle dmem_write=0, state IDLE.
//    A resp then arrives -> no wb_valid.
//  - MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, never resp -> DONE after 4 cycles; mem_err=1, wb_mdr=16'h0000.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage and the data memory.
// The stage drives address/strobes/data; the memory returns rdata with a one-cycle resp.
interface mem_stage_if;
    logic [15:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [1:0]  dmem_byte_en;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;

    modport master (
        output dmem_address, dmem_read, dmem_write, dmem_byte_en, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_address, dmem_read, dmem_write, dmem_byte_en, dmem_wdata,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_stage.sv
// LC-3b MEM stage: runs LDR/LDB/STR/STB and two-access LDI/STI handshakes, registers results into MEM/WB.
// Latency: non-memory ops 1 cycle; plain load/store 3 cycles, LDI/STI 4 cycles with resp one cycle after the strobe.
// Backpressure: stall_o holds upstream while an access is outstanding; MEM_TIMEOUT_EN adds a bounded wait with sticky mem_err.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic        in_read,
    input  logic        in_write,
    input  logic        in_byte,
    input  logic        in_indirect,
    input  logic [15:0] in_addr,
    input  logic [15:0] in_src,
    input  logic [15:0] in_alu,
    input  logic [15:0] in_pc,
    output logic        stall_o,
    mem_stage_if.master dmem,
    output logic        wb_valid,
    output logic [15:0] wb_mar,
    output logic [15:0] wb_mdr,
    output logic [15:0] wb_alu,
    output logic [15:0] wb_pc,
    output logic        mem_err
);
    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] mar_q, mar_d, mdr_q, mdr_d;
    logic        wb_valid_q, wb_valid_d;
    logic [15:0] wb_mar_q, wb_mar_d, wb_mdr_q, wb_mdr_d;
    logic [15:0] wb_alu_q, wb_alu_d, wb_pc_q, wb_pc_d;
    logic        mem_op, wb_load, byte_st, in_acc;

    assign mem_op  = in_read | in_write;
    assign in_acc  = (state_q == ACC1) || (state_q == ACC2);
    assign stall_o = in_valid & (state_q != DONE) & (mem_op | (state_q != IDLE));

    // The pointer fetch of LDI/STI is always a full-word read, whatever in_byte says.
    assign byte_st = in_byte & in_write & ~(in_indirect & (state_q == ACC1));

    assign dmem.dmem_address = {mar_q[15:1], 1'b0};
    assign dmem.dmem_wdata   = byte_st ? {in_src[7:0], in_src[7:0]} : in_src;
    assign dmem.dmem_byte_en = byte_st ? (mar_q[0] ? 2'b10 : 2'b01) : 2'b11;
    assign dmem.dmem_read    = ((state_q == ACC1) & (in_read | in_indirect)) |
                               ((state_q == ACC2) & in_read);
    assign dmem.dmem_write   = ((state_q == ACC1) & in_write & ~in_indirect) |
                               ((state_q == ACC2) & in_write);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    assign mem_err = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign mem_err    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        wb_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && mem_op) begin
                    state_d = ACC1;
                    mar_d   = in_addr;
                end else if (in_valid) begin
                    wb_load = 1'b1;
                end
            end
            ACC1: begin
                if (dmem.dmem_resp) begin
                    if (in_indirect) begin
                        state_d = ACC2;
                        mar_d   = dmem.dmem_rdata;
                    end else begin
                        state_d = DONE;
                        if (in_read) mdr_d = dmem.dmem_rdata;
                    end
                end
            end
            ACC2: begin
                if (dmem.dmem_resp) begin
                    state_d = DONE;
                    if (in_read) mdr_d = dmem.dmem_rdata;
                end
            end
            default: begin
                wb_load = 1'b1;
                state_d = IDLE;
            end
        endcase
`ifdef MEM_TIMEOUT_EN
        err_d = err_q;
        if (in_acc && !dmem.dmem_resp && (cnt_q == 8'(TIMEOUT_CYCLES - 1))) begin
            state_d = DONE;
            mdr_d   = 16'h0000;
            err_d   = 1'b1;
        end
        // Counter restarts whenever an access phase is (re)entered.
        cnt_d = (in_acc && (state_d == state_q)) ? cnt_q + 8'd1 : 8'd0;
`endif
        wb_valid_d = wb_load;
        wb_mar_d   = wb_load ? mar_q  : wb_mar_q;
        wb_mdr_d   = wb_load ? mdr_q  : wb_mdr_q;
        wb_alu_d   = wb_load ? in_alu : wb_alu_q;
        wb_pc_d    = wb_load ? in_pc  : wb_pc_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mar_q      <= 16'h0000;
            mdr_q      <= 16'h0000;
            wb_valid_q <= 1'b0;
            wb_mar_q   <= 16'h0000;
            wb_mdr_q   <= 16'h0000;
            wb_alu_q   <= 16'h0000;
            wb_pc_q    <= 16'h0000;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= 8'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mar_q      <= mar_d;
            mdr_q      <= mdr_d;
            wb_valid_q <= wb_valid_d;
            wb_mar_q   <= wb_mar_d;
            wb_mdr_q   <= wb_mdr_d;
            wb_alu_q   <= wb_alu_d;
            wb_pc_q    <= wb_pc_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_mar   = wb_mar_q;
    assign wb_mdr   = wb_mdr_q;
    assign wb_alu   = wb_alu_q;
    assign wb_pc    = wb_pc_q;
endmodule
